// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : fetch, load/store and memory-port signals of the arbiter
// Revision 1.0
// ============================================================================
interface mem_port_arbiter_if;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        ifValid;
    logic        ifErr;
    logic [31:0] ifInstr;
    logic [1:0]  memOp;
    logic [1:0]  memSize;
    logic        loadUnsigned;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic        dValid;
    logic        dErr;
    logic [31:0] dRdata;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic [3:0]  memBe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memReady;

    modport slave (
        input  ifReq, ifAddr, memOp, memSize, loadUnsigned, dAddr, dWdata,
               memRdata, memReady,
        output ifValid, ifErr, ifInstr, dValid, dErr, dRdata, stall,
               memReq, memWe, memBe, memAddr, memWdata
    );

    modport master (
        output ifReq, ifAddr, memOp, memSize, loadUnsigned, dAddr, dWdata,
               memRdata, memReady,
        input  ifValid, ifErr, ifInstr, dValid, dErr, dRdata, stall,
               memReq, memWe, memBe, memAddr, memWdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch and load/store,
//                    with pipeline stall, lane alignment and error reporting
// Revision 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_port_arbiter_if.slave bus
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_FETCH  = 3'd2,
        S_RESP_D = 3'd3,
        S_RESP_F = 3'd4
    } state_t;

    state_t        state_q;
    logic          lastGrantData_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          isStore_q;
    logic          memReq_q, memWe_q;
    logic [3:0]    memBe_q;
    logic [31:0]   memAddr_q, memWdata_q;
    logic          dValid_q, dErr_q, ifValid_q, ifErr_q;
    logic [31:0]   dRdata_q, ifInstr_q;

    logic          w_dReq, w_isStore, w_dMis, w_fMis, w_grantData, w_timeout;
    logic [3:0]    w_dBe;
    logic [31:0]   w_wdata, w_shift, w_load;

    assign w_dReq      = (bus.memOp == 2'b01) || (bus.memOp == 2'b10);
    assign w_isStore   = (bus.memOp == 2'b10);
    assign w_dMis      = (bus.memSize == 2'b11)
                       || ((bus.memSize == 2'b01) && bus.dAddr[0])
                       || ((bus.memSize == 2'b10) && (bus.dAddr[1:0] != 2'b00));
    assign w_fMis      = (bus.ifAddr[1:0] != 2'b00);
    // On contention the side not served last wins; lastGrantData_q=0 means fetch.
    assign w_grantData = w_dReq && (!bus.ifReq || !lastGrantData_q);
    assign w_timeout   = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        w_dBe   = 4'b0000;
        w_wdata = 32'h0;
        case (bus.memSize)
            2'b00: begin
                w_dBe   = 4'b0001 << bus.dAddr[1:0];
                w_wdata = {4{bus.dWdata[7:0]}};
            end
            2'b01: begin
                w_dBe   = bus.dAddr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.dWdata[15:0]}};
            end
            default: begin
                w_dBe   = 4'b1111;
                w_wdata = bus.dWdata;
            end
        endcase
    end

    assign w_shift = bus.memRdata >> {lane_q, 3'b000};

    always_comb begin
        w_load = bus.memRdata;
        case (size_q)
            2'b00:   w_load = {{24{~uns_q & w_shift[7]}},  w_shift[7:0]};
            2'b01:   w_load = {{16{~uns_q & w_shift[15]}}, w_shift[15:0]};
            default: w_load = bus.memRdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            lastGrantData_q <= 1'b0;
            cnt_q           <= '0;
            lane_q          <= 2'b00;
            size_q          <= 2'b00;
            uns_q           <= 1'b0;
            isStore_q       <= 1'b0;
            memReq_q        <= 1'b0;
            memWe_q         <= 1'b0;
            memBe_q         <= 4'b0000;
            memAddr_q       <= 32'h0;
            memWdata_q      <= 32'h0;
            dValid_q        <= 1'b0;
            dErr_q          <= 1'b0;
            dRdata_q        <= 32'h0;
            ifValid_q       <= 1'b0;
            ifErr_q         <= 1'b0;
            ifInstr_q       <= 32'h0;
        end else begin
            dValid_q  <= 1'b0;
            ifValid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_grantData) begin
                        if (w_dMis) begin
                            state_q  <= S_RESP_D;
                            dValid_q <= 1'b1;
                            dErr_q   <= 1'b1;
                            dRdata_q <= 32'h0;
                        end else begin
                            state_q    <= S_DATA;
                            memReq_q   <= 1'b1;
                            memWe_q    <= w_isStore;
                            memBe_q    <= w_dBe;
                            memAddr_q  <= {bus.dAddr[31:2], 2'b00};
                            memWdata_q <= w_isStore ? w_wdata : 32'h0;
                            lane_q     <= bus.dAddr[1:0];
                            size_q     <= bus.memSize;
                            uns_q      <= bus.loadUnsigned;
                            isStore_q  <= w_isStore;
                            cnt_q      <= '0;
                        end
                    end else if (bus.ifReq) begin
                        if (w_fMis) begin
                            state_q   <= S_RESP_F;
                            ifValid_q <= 1'b1;
                            ifErr_q   <= 1'b1;
                            ifInstr_q <= 32'h0;
                        end else begin
                            state_q    <= S_FETCH;
                            memReq_q   <= 1'b1;
                            memWe_q    <= 1'b0;
                            memBe_q    <= 4'b1111;
                            memAddr_q  <= {bus.ifAddr[31:2], 2'b00};
                            memWdata_q <= 32'h0;
                            cnt_q      <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.memReady || w_timeout) begin
                        state_q  <= S_RESP_D;
                        memReq_q <= 1'b0;
                        dValid_q <= 1'b1;
                        dErr_q   <= !bus.memReady;
                        dRdata_q <= (bus.memReady && !isStore_q) ? w_load : 32'h0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_FETCH: begin
                    if (bus.memReady || w_timeout) begin
                        state_q   <= S_RESP_F;
                        memReq_q  <= 1'b0;
                        ifValid_q <= 1'b1;
                        ifErr_q   <= !bus.memReady;
                        ifInstr_q <= bus.memReady ? bus.memRdata : 32'h0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESP_D: begin
                    lastGrantData_q <= 1'b1;
                    state_q         <= S_IDLE;
                end
                S_RESP_F: begin
                    lastGrantData_q <= 1'b0;
                    state_q         <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Released during RESP_D so the latch advances at the end of that cycle.
    assign bus.stall    = reset && w_dReq && (state_q != S_RESP_D);
    assign bus.memReq   = memReq_q;
    assign bus.memWe    = memWe_q;
    assign bus.memBe    = memBe_q;
    assign bus.memAddr  = memAddr_q;
    assign bus.memWdata = memWdata_q;
    assign bus.dValid   = dValid_q;
    assign bus.dErr     = dErr_q;
    assign bus.dRdata   = dRdata_q;
    assign bus.ifValid  = ifValid_q;
    assign bus.ifErr    = ifErr_q;
    assign bus.ifInstr  = ifInstr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Revision 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    // memory responder settings
    int          waitStates;
    bit          stuck;
    int          reqAge;
    int          reqCycles;
    logic [31:0] memData;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge and play the memory side for this cycle.
    task automatic tick();
        @(negedge clk);
        if (bus.memReq === 1'b1) begin
            reqCycles++;
            bus.memReady = (!stuck && (reqAge >= waitStates));
            reqAge++;
        end else begin
            bus.memReady = 1'b0;
            reqAge = 0;
        end
        bus.memRdata = memData;
    endtask

    task automatic idle_inputs();
        bus.ifReq        = 1'b0;
        bus.ifAddr       = 32'h0;
        bus.memOp        = 2'b00;
        bus.memSize      = 2'b00;
        bus.loadUnsigned = 1'b0;
        bus.dAddr        = 32'h0;
        bus.dWdata       = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        bus.memReady = 1'b0;
        bus.memRdata = 32'h0;
        tick(); tick();
        bus.memOp = 2'b01;
        #1;
        vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %h want 0", bus.stall); end
        vectors++; if (bus.memReq !== 1'b0) begin miscompares++; $display("FAIL rst_memreq: got %h want 0", bus.memReq); end
        vectors++; if (bus.dValid !== 1'b0 || bus.ifValid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got d=%h if=%h want 0", bus.dValid, bus.ifValid); end
        vectors++; if (bus.dRdata !== 32'h0 || bus.ifInstr !== 32'h0) begin miscompares++; $display("FAIL rst_data: got d=%h if=%h want 0", bus.dRdata, bus.ifInstr); end
        vectors++; if (bus.memBe !== 4'h0 || bus.memAddr !== 32'h0) begin miscompares++; $display("FAIL rst_bus: got be=%h addr=%h want 0", bus.memBe, bus.memAddr); end
        bus.memOp = 2'b00;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_word_load();
        waitStates = 0; reqCycles = 0; memData = 32'hDEADBEEF;
        bus.memOp = 2'b01; bus.memSize = 2'b10; bus.dAddr = 32'h1000;
        #1;
        vectors++; if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL wl_stall0: got %h want 1", bus.stall); end
        tick();
        vectors++; if (bus.memReq !== 1'b1 || bus.stall !== 1'b1) begin miscompares++; $display("FAIL wl_cyc1: got req=%h stall=%h want 1 1", bus.memReq, bus.stall); end
        vectors++; if (bus.memAddr !== 32'h1000 || bus.memBe !== 4'hF || bus.memWe !== 1'b0) begin miscompares++; $display("FAIL wl_bus: got addr=%h be=%h we=%h want 1000 f 0", bus.memAddr, bus.memBe, bus.memWe); end
        tick();
        vectors++; if (bus.dValid !== 1'b1 || bus.dErr !== 1'b0) begin miscompares++; $display("FAIL wl_valid: got v=%h e=%h want 1 0", bus.dValid, bus.dErr); end
        vectors++; if (bus.dRdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wl_data: got %h want deadbeef", bus.dRdata); end
        vectors++; if (bus.stall !== 1'b0 || bus.memReq !== 1'b0) begin miscompares++; $display("FAIL wl_cyc2: got stall=%h req=%h want 0 0", bus.stall, bus.memReq); end
        vectors++; if (reqCycles != 1) begin miscompares++; $display("FAIL wl_reqcyc: got %0d want 1", reqCycles); end
        idle_inputs();
        tick();
        vectors++; if (bus.dValid !== 1'b0 || bus.dRdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wl_hold: got v=%h d=%h want 0 deadbeef", bus.dValid, bus.dRdata); end
    endtask

    task automatic test_byte_load();
        waitStates = 0; memData = 32'h80123456;
        bus.memOp = 2'b01; bus.memSize = 2'b00; bus.dAddr = 32'h1003; bus.loadUnsigned = 1'b0;
        tick();
        vectors++; if (bus.memBe !== 4'b1000 || bus.memAddr !== 32'h1000) begin miscompares++; $display("FAIL bl_be: got be=%b addr=%h want 1000 1000", bus.memBe, bus.memAddr); end
        tick();
        vectors++; if (bus.dValid !== 1'b1 || bus.dRdata !== 32'hFFFFFF80) begin miscompares++; $display("FAIL bl_signed: got v=%h d=%h want 1 ffffff80", bus.dValid, bus.dRdata); end
        idle_inputs();
        tick();
        waitStates = 1;
        bus.memOp = 2'b01; bus.memSize = 2'b00; bus.dAddr = 32'h1003; bus.loadUnsigned = 1'b1;
        tick();
        tick();
        vectors++; if (bus.dValid !== 1'b0 || bus.stall !== 1'b1 || bus.memReq !== 1'b1) begin miscompares++; $display("FAIL bl_wait: got v=%h stall=%h req=%h want 0 1 1", bus.dValid, bus.stall, bus.memReq); end
        tick();
        vectors++; if (bus.dValid !== 1'b1 || bus.dRdata !== 32'h00000080) begin miscompares++; $display("FAIL bl_unsigned: got v=%h d=%h want 1 00000080", bus.dValid, bus.dRdata); end
        idle_inputs();
        tick();
    endtask

    task automatic test_store();
        waitStates = 0; memData = 32'h12345678;
        bus.memOp = 2'b10; bus.memSize = 2'b01; bus.dAddr = 32'h2002; bus.dWdata = 32'h0000ABCD;
        tick();
        vectors++; if (bus.memWe !== 1'b1 || bus.memBe !== 4'b1100) begin miscompares++; $display("FAIL hs_we_be: got we=%h be=%b want 1 1100", bus.memWe, bus.memBe); end
        vectors++; if (bus.memWdata !== 32'hABCDABCD || bus.memAddr !== 32'h2000) begin miscompares++; $display("FAIL hs_wdata: got wd=%h addr=%h want abcdabcd 2000", bus.memWdata, bus.memAddr); end
        tick();
        vectors++; if (bus.dValid !== 1'b1 || bus.dErr !== 1'b0 || bus.dRdata !== 32'h0) begin miscompares++; $display("FAIL hs_done: got v=%h e=%h d=%h want 1 0 0", bus.dValid, bus.dErr, bus.dRdata); end
        idle_inputs();
        tick();
        bus.memOp = 2'b10; bus.memSize = 2'b00; bus.dAddr = 32'h2001; bus.dWdata = 32'hFFFFFF5A;
        tick();
        vectors++; if (bus.memBe !== 4'b0010 || bus.memWdata !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL bs_lane: got be=%b wd=%h want 0010 5a5a5a5a", bus.memBe, bus.memWdata); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_misaligned();
        reqCycles = 0;
        bus.memOp = 2'b01; bus.memSize = 2'b10; bus.dAddr = 32'h2001;
        #1;
        vectors++; if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL mis_stall0: got %h want 1", bus.stall); end
        tick();
        vectors++; if (bus.dValid !== 1'b1 || bus.dErr !== 1'b1 || bus.dRdata !== 32'h0) begin miscompares++; $display("FAIL mis_err: got v=%h e=%h d=%h want 1 1 0", bus.dValid, bus.dErr, bus.dRdata); end
        vectors++; if (bus.memReq !== 1'b0 || bus.stall !== 1'b0) begin miscompares++; $display("FAIL mis_noreq: got req=%h stall=%h want 0 0", bus.memReq, bus.stall); end
        idle_inputs();
        tick();
        vectors++; if (reqCycles != 0) begin miscompares++; $display("FAIL mis_reqcyc: got %0d want 0", reqCycles); end
        bus.ifReq = 1'b1; bus.ifAddr = 32'h102;
        tick();
        vectors++; if (bus.ifValid !== 1'b1 || bus.ifErr !== 1'b1 || bus.memReq !== 1'b0) begin miscompares++; $display("FAIL mis_fetch: got v=%h e=%h req=%h want 1 1 0", bus.ifValid, bus.ifErr, bus.memReq); end
        idle_inputs();
        tick();
    endtask

    task automatic test_arbitration();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        waitStates = 0; memData = 32'h11112222;
        bus.ifReq = 1'b1; bus.ifAddr = 32'h400;
        bus.memOp = 2'b01; bus.memSize = 2'b10; bus.dAddr = 32'h1000;
        tick();
        vectors++; if (bus.memAddr !== 32'h1000 || bus.memReq !== 1'b1) begin miscompares++; $display("FAIL arb_first: got addr=%h req=%h want 1000 1", bus.memAddr, bus.memReq); end
        tick();
        vectors++; if (bus.dValid !== 1'b1 || bus.ifValid !== 1'b0 || bus.dRdata !== 32'h11112222) begin miscompares++; $display("FAIL arb_d1: got dv=%h iv=%h d=%h want 1 0 11112222", bus.dValid, bus.ifValid, bus.dRdata); end
        bus.dAddr = 32'h1004; memData = 32'hCAFEF00D;
        tick();
        vectors++; if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL arb_idle_stall: got %h want 1", bus.stall); end
        tick();
        vectors++; if (bus.memAddr !== 32'h400 || bus.memBe !== 4'hF || bus.memWe !== 1'b0) begin miscompares++; $display("FAIL arb_fetch: got addr=%h be=%h we=%h want 400 f 0", bus.memAddr, bus.memBe, bus.memWe); end
        vectors++; if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL arb_fetch_stall: got %h want 1", bus.stall); end
        tick();
        vectors++; if (bus.ifValid !== 1'b1 || bus.ifErr !== 1'b0 || bus.ifInstr !== 32'hCAFEF00D || bus.stall !== 1'b1) begin miscompares++; $display("FAIL arb_fresp: got v=%h e=%h i=%h stall=%h want 1 0 cafef00d 1", bus.ifValid, bus.ifErr, bus.ifInstr, bus.stall); end
        bus.ifAddr = 32'h404; memData = 32'h33334444;
        tick();
        tick();
        vectors++; if (bus.memAddr !== 32'h1004 || bus.memReq !== 1'b1) begin miscompares++; $display("FAIL arb_data2: got addr=%h req=%h want 1004 1", bus.memAddr, bus.memReq); end
        tick();
        vectors++; if (bus.dValid !== 1'b1 || bus.dRdata !== 32'h33334444) begin miscompares++; $display("FAIL arb_d2: got v=%h d=%h want 1 33334444", bus.dValid, bus.dRdata); end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int  cyc;
        bit  seen;
        stuck = 1'b1; reqCycles = 0; cyc = 0; seen = 1'b0; memData = 32'h5555AAAA;
        bus.memOp = 2'b01; bus.memSize = 2'b10; bus.dAddr = 32'h3000;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            cyc++;
            if (bus.dValid === 1'b1) seen = 1'b1;
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL to_bound: got no dValid in 20 cycles want dValid"); end
        vectors++; if (cyc != 5) begin miscompares++; $display("FAIL to_latency: got cycle %0d want 5", cyc); end
        vectors++; if (reqCycles != 4) begin miscompares++; $display("FAIL to_reqcyc: got %0d want 4", reqCycles); end
        vectors++; if (bus.dErr !== 1'b1 || bus.dRdata !== 32'h0) begin miscompares++; $display("FAIL to_err: got e=%h d=%h want 1 0", bus.dErr, bus.dRdata); end
        stuck = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        waitStates = 3; memData = 32'h0BADF00D;
        bus.memOp = 2'b01; bus.memSize = 2'b10; bus.dAddr = 32'h1000;
        tick();
        vectors++; if (bus.memReq !== 1'b1) begin miscompares++; $display("FAIL ar_req: got %h want 1", bus.memReq); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (bus.memReq !== 1'b0 || bus.stall !== 1'b0) begin miscompares++; $display("FAIL ar_async: got req=%h stall=%h want 0 0", bus.memReq, bus.stall); end
        waitStates = 0;
        tick();
        reset = 1'b1;
        #1;
        vectors++; if (bus.stall !== 1'b1 || bus.memReq !== 1'b0) begin miscompares++; $display("FAIL ar_idle: got stall=%h req=%h want 1 0", bus.stall, bus.memReq); end
        tick();
        vectors++; if (bus.memReq !== 1'b1 || bus.memAddr !== 32'h1000) begin miscompares++; $display("FAIL ar_restart: got req=%h addr=%h want 1 1000", bus.memReq, bus.memAddr); end
        tick();
        vectors++; if (bus.dValid !== 1'b1 || bus.dRdata !== 32'h0BADF00D) begin miscompares++; $display("FAIL ar_done: got v=%h d=%h want 1 0badf00d", bus.dValid, bus.dRdata); end
        idle_inputs();
        tick();
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        waitStates = 0; stuck = 1'b0; reqAge = 0; reqCycles = 0; memData = 32'h0;
        test_reset();
        test_word_load();
        test_byte_load();
        test_store();
        test_misaligned();
        test_arbitration();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port between instruction fetch and the load/store stage. It sits directly after the execute/memory pipeline latch. It also generates the pipeline `stall` that freezes that latch and upstream stages until a data access completes. Store data is lane-aligned and byte enables are derived on the way out; load data is aligned and sign/zero-extended on the way back. Misaligned accesses and memory timeouts are reported as errors.

## Interface
- `TIMEOUT`, 255: maximum number of cycles `memReq` stays high without `memReady` before the access is aborted; legal range ≥1.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ifReq`  in  1  fetch request; held high by fetch until `ifValid`.
- `ifAddr`  in  32  fetch byte address.
- `ifValid`  out  1  one-cycle pulse: fetch complete.
- `ifErr`  out  1  qualifies `ifValid`: misaligned address or timeout.
- `ifInstr`  out  32  fetched word; held until the next fetch completion.
- `memOp`  in  2  encoding: 00 disable, 01 load, 10 store, 11 treated as disable.
- `memSize`  in  2  encoding: 00 byte, 01 half, 10 word, 11 illegal.
- `loadUnsigned`  in  1  1 = zero-extend loads, 0 = sign-extend.
- `dAddr`  in  32  data byte address (ALU result).
- `dWdata`  in  32  store data, right-justified.
- `dValid`  out  1  one-cycle pulse: data access complete.
- `dErr`  out  1  qualifies `dValid`: misaligned, illegal size, or timeout.
- `dRdata`  out  32  extended load result; held until the next data completion.
- `stall`  out  1  combinational; freezes the pipeline latches.
- `memReq`  out  1  memory request.
- `memWe`  out  1  write enable.
- `memBe`  out  4  byte enables.
- `memAddr`  out  32  word address; {dAddr[31:2],2'b00}.
- `memWdata`  out  32  lane-replicated store data.
- `memRdata`  in  32  read data; valid with `memReady`.
- `memReady`  in  1  access accepted and complete in this cycle.

## Operation
- `dReq` = (`memOp`==01 || `memOp`==10).
- States:
  - IDLE
  - DATA, FETCH: memory access in flight.
  - RESP_D, RESP_F: one-cycle result presentation.
- IDLE transitions:
  - Data only → DATA.
  - Fetch only → FETCH.
  - Both requesting: grant the requester not granted last (`lastGrant`). `lastGrant` resets to "fetch", so data wins first.
- Misaligned requests skip the access state and go IDLE → RESP_D/RESP_F with err=1. Misaligned means: half with addr[0]=1, word with addr[1:0]≠0, `memSize`=11, or fetch with ifAddr[1:0]≠0. No `memReq` is issued.
- `memAddr`, `memWe`, `memBe` and `memWdata` are registered on the IDLE→DATA/FETCH edge and held stable while `memReq`=1.
- `memBe`:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 0011 when addr[1]=0, else 1100.
  - Word: 1111.
  - Fetch: 1111.
- `memWdata`: byte → {4{d[7:0]}}, half → {2{d[15:0]}}, word → d. Zero on loads and fetches.
- DATA/FETCH: if `memReady`=1, capture the result and go to RESP_D/RESP_F.
- Timeout: a counter clears on entry and increments each cycle `memReady`=0. If counter==TIMEOUT-1 and `memReady`=0, go to RESP with err=1 and leave the result register at 0.
- Load extraction: select the lane by addr[1:0], then extend to 32 bits per `loadUnsigned`. Stores complete with `dRdata`=0.
- RESP_D: `dValid`=1, update `lastGrant`=data, then → IDLE. RESP_F is symmetric, with `lastGrant`=fetch.
- `stall` = `reset` && `dReq` && (state≠RESP_D). The latch therefore advances at the end of the RESP_D cycle, and the next instruction's `memOp` is seen in IDLE.
- Reset values, applied asynchronously:
  - state IDLE; `lastGrant`=fetch; counter 0.
  - All registered outputs 0.
  - A request in flight is abandoned and `memReq` drops immediately.

## Timing
- Zero-wait data access:
  - Cycle 0: IDLE, `stall`=1.
  - Cycle 1: DATA, `memReq`=1, `memReady`=1.
  - Cycle 2: RESP_D, `dValid`=1, `stall`=0.
- Each wait state adds one cycle.
- Misaligned data access: cycle 0 IDLE, cycle 1 RESP_D with err.
- Fetch has the same latency as data, with `ifValid` in RESP_F. `stall` is unaffected by fetch.
- A back-to-back data access starts one cycle after RESP_D, through IDLE.
- When fetch is granted while data is pending, `stall` stays high through the fetch.

## Test plan
- Word load 0x1000, `memRdata`=0xDEADBEEF, memReady in the first cycle → `memReq`=1 for 1 cycle, `dValid` at cycle 2, `dRdata`=0xDEADBEEF, `stall` high in cycles 0–1 only.
- Byte load 0x1003 with `memRdata`=0x80xxxxxx:
  - signed → `dRdata`=0xFFFFFF80, `memBe`=1000.
  - unsigned → 0x00000080.
- Half store 0x2002, `dWdata`=0x0000ABCD → `memWe`=1, `memBe`=1100, `memWdata`=0xABCDABCD. Word load at 0x2001 → err, `memReq` never asserts.
- `ifReq` and data load both in IDLE after reset → data served first. Next grant is fetch even though a new data request is present, then data again.
- TIMEOUT=4, `memReady` stuck 0 → `memReq` high exactly 4 cycles, then `dValid`=`dErr`=1, `dRdata`=0.
- `reset` low during DATA → `memReq`, `stall` and state clear asynchronously. After release, the still-present request restarts from IDLE.
